// File: rtl/stream_pkg.sv
// Shared definitions for the stream coprocessor input and output stages.
package stream_pkg;
   localparam int DEF_SIZECOUNT = 12;
   localparam int DEF_DATAWIDTH = 32;
   localparam int DEF_FIFOLOG2  = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;
endpackage

// File: rtl/out_fifo.sv
// Show-ahead elastic FIFO with registered full/empty flags.
// A push while full is taken only when a pop frees a slot in the same cycle.
module out_fifo #(
   parameter int DATAWIDTH = 32,
   parameter int FIFOLOG2  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush_i,
   input  logic                 push_i,
   input  logic [DATAWIDTH-1:0] data_i,
   input  logic                 pop_i,
   output logic [DATAWIDTH-1:0] head_o,
   output logic                 full_o,
   output logic                 empty_o
);
   localparam int DEPTH = 1 << FIFOLOG2;
   localparam logic [FIFOLOG2-1:0] PTR_ONE   = FIFOLOG2'(1);
   localparam logic [FIFOLOG2:0]   CNT_ONE   = (FIFOLOG2 + 1)'(1);
   localparam logic [FIFOLOG2:0]   CNT_DEPTH = (FIFOLOG2 + 1)'(DEPTH);

   logic [DATAWIDTH-1:0] mem_q [DEPTH];
   logic [FIFOLOG2-1:0]  wr_ptr_q, wr_ptr_d;
   logic [FIFOLOG2-1:0]  rd_ptr_q, rd_ptr_d;
   logic [FIFOLOG2:0]    cnt_q, cnt_d;
   logic                 full_q, full_d;
   logic                 empty_q, empty_d;
   logic                 do_push_s, do_pop_s;

   // Pointer/occupancy next state; flush wins over any push or pop.
   always_comb begin
      do_pop_s  = pop_i && !empty_q;
      do_push_s = push_i && (!full_q || do_pop_s);
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      cnt_d     = cnt_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({do_push_s, do_pop_s})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
         endcase
      end
      full_d  = (cnt_d == CNT_DEPTH);
      empty_d = (cnt_d == '0);
   end

   // Pointer, occupancy and flag registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   // Storage; cleared on reset so the head reads zero until the first push.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (do_push_s && !flush_i) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign full_o  = full_q;
   assign empty_o = empty_q;
endmodule

// File: rtl/back_end.sv
// Output stage: takes exactly `size` datapath tokens per run through a small
// FIFO and writes them to the FSL master port, tagging the last word.
module back_end
   import stream_pkg::*;
#(
   parameter int SIZECOUNT = DEF_SIZECOUNT,
   parameter int DATAWIDTH = DEF_DATAWIDTH,
   parameter int FIFOLOG2  = DEF_FIFOLOG2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 clear,
   input  logic [SIZECOUNT-1:0] size,
   input  logic [DATAWIDTH-1:0] OUT_data,
   input  logic                 OUT_send,
   output logic                 IN_rdy,
   output logic [DATAWIDTH-1:0] FSL_M_DATA,
   output logic                 FSL_M_WRITE,
   output logic                 FSL_M_CONTROL,
   input  logic                 FSL_M_FULL,
   output logic                 done
);
   localparam logic [SIZECOUNT-1:0] CNT_ONE = SIZECOUNT'(1);

   state_t               state_q, state_d;
   logic [SIZECOUNT-1:0] size_q, size_d;
   logic [SIZECOUNT-1:0] acc_cnt_q, acc_cnt_d;
   logic [SIZECOUNT-1:0] wr_cnt_q, wr_cnt_d;
   logic                 in_rdy_s, wr_s, accept_s;
   logic                 fifo_full_s, fifo_empty_s;
   logic [DATAWIDTH-1:0] fifo_head_s;

   out_fifo #(
      .DATAWIDTH (DATAWIDTH),
      .FIFOLOG2  (FIFOLOG2)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush_i (clear),
      .push_i  (accept_s),
      .data_i  (OUT_data),
      .pop_i   (wr_s),
      .head_o  (fifo_head_s),
      .full_o  (fifo_full_s),
      .empty_o (fifo_empty_s)
   );

   // Handshakes depend only on registered state and FSL_M_FULL, never on OUT_send.
   always_comb begin
      in_rdy_s = 1'b0;
      wr_s     = 1'b0;
      case (state_q)
         ST_RUN: begin
            in_rdy_s = !fifo_full_s && (acc_cnt_q < size_q);
            wr_s     = !fifo_empty_s && !FSL_M_FULL;
         end
         ST_DRAIN: begin
            in_rdy_s = 1'b0;
            wr_s     = !fifo_empty_s && !FSL_M_FULL;
         end
         default: begin
            in_rdy_s = 1'b0;
            wr_s     = 1'b0;
         end
      endcase
      accept_s = OUT_send && in_rdy_s;
   end

   // FSM and counter next state; clear overrides everything else.
   always_comb begin
      state_d   = state_q;
      size_d    = size_q;
      acc_cnt_d = acc_cnt_q;
      wr_cnt_d  = wr_cnt_q;
      if (clear) begin
         state_d   = ST_IDLE;
         acc_cnt_d = '0;
         wr_cnt_d  = '0;
      end else begin
         if (accept_s) begin
            acc_cnt_d = acc_cnt_q + CNT_ONE;
         end else begin
            acc_cnt_d = acc_cnt_q;
         end
         if (wr_s) begin
            wr_cnt_d = wr_cnt_q + CNT_ONE;
         end else begin
            wr_cnt_d = wr_cnt_q;
         end
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  size_d    = size;
                  acc_cnt_d = '0;
                  wr_cnt_d  = '0;
                  state_d   = (size == '0) ? ST_DONE : ST_RUN;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_RUN: begin
               if (acc_cnt_d == size_q) begin
                  state_d = ST_DRAIN;
               end else begin
                  state_d = ST_RUN;
               end
            end
            ST_DRAIN: begin
               if (wr_cnt_d == size_q) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_DRAIN;
               end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // State and counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         size_q    <= '0;
         acc_cnt_q <= '0;
         wr_cnt_q  <= '0;
      end else begin
         state_q   <= state_d;
         size_q    <= size_d;
         acc_cnt_q <= acc_cnt_d;
         wr_cnt_q  <= wr_cnt_d;
      end
   end

   assign IN_rdy        = in_rdy_s;
   assign FSL_M_WRITE   = wr_s;
   assign FSL_M_DATA    = fifo_head_s;
   assign FSL_M_CONTROL = wr_s && (wr_cnt_q == (size_q - CNT_ONE));
   assign done          = (state_q == ST_DONE);
endmodule

// File: tb/tb_back_end.sv
// Bench for back_end: table of runs plus random runs checked by a queue-based
// reference model, and hand-written multi-cycle corner cases.
module tb_back_end;
   logic        clk;
   logic        rst;
   logic        start;
   logic        clear;
   logic [11:0] size_i;
   logic [31:0] OUT_data;
   logic        OUT_send;
   logic        IN_rdy;
   logic [31:0] FSL_M_DATA;
   logic        FSL_M_WRITE;
   logic        FSL_M_CONTROL;
   logic        fsl_full;
   logic        done;

   back_end dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .clear         (clear),
      .size          (size_i),
      .OUT_data      (OUT_data),
      .OUT_send      (OUT_send),
      .IN_rdy        (IN_rdy),
      .FSL_M_DATA    (FSL_M_DATA),
      .FSL_M_WRITE   (FSL_M_WRITE),
      .FSL_M_CONTROL (FSL_M_CONTROL),
      .FSL_M_FULL    (fsl_full),
      .done          (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      int sz;
      int full_pct;
      int send_pct;
      bit seq;
      int exp_wr;
      int exp_ctrl;
      bit tput;
   } vec_t;

   vec_t vecs [7];

   int chk_cnt  = 0;
   int pass_cnt = 0;
   int cyc      = 0;

   // reference model state
   logic [31:0] exp_q [$];
   int  run_size, acc_seen, wr_seen, ctrl_seen, first_wr, last_wr;
   bit  busy, done_due;
   logic s_in_rdy, s_wr;

   task automatic check(input string name, input longint act, input longint exp);
      chk_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic model_new(input int sz);
      exp_q.delete();
      run_size  = sz;
      acc_seen  = 0;
      wr_seen   = 0;
      ctrl_seen = 0;
      first_wr  = -1;
      last_wr   = -1;
      busy      = 1'b0;
      done_due  = 1'b0;
   endtask

   // One clock: sample at negedge, update the model, return at posedge+1.
   task automatic tick();
      bit due_now;
      bit new_due;
      @(negedge clk);
      s_in_rdy = IN_rdy;
      s_wr     = FSL_M_WRITE;
      due_now  = done_due;
      new_due  = 1'b0;
      if (FSL_M_WRITE) begin
         check("wr_while_full", fsl_full, 0);
         if (exp_q.size() == 0 || wr_seen >= run_size) begin
            check("wr_unexpected", 1, 0);
         end else begin
            check("wr_data", FSL_M_DATA, exp_q.pop_front());
            check("wr_ctrl", FSL_M_CONTROL, (wr_seen == run_size - 1));
            if (FSL_M_CONTROL) ctrl_seen++;
            wr_seen++;
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
            if (wr_seen == run_size) new_due = 1'b1;
         end
      end else if (FSL_M_CONTROL) begin
         check("ctrl_without_wr", 1, 0);
      end
      if (OUT_send && IN_rdy) begin
         acc_seen++;
         check("accept_quota", (acc_seen <= run_size), 1);
         exp_q.push_back(OUT_data);
      end
      if (start && !busy) begin
         busy = 1'b1;
         if (size_i == 12'd0) new_due = 1'b1;
      end
      if (done || due_now) check("done", done, due_now);
      if (done) busy = 1'b0;
      done_due = new_due;
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic recover();
      clear    = 1'b1;
      OUT_send = 1'b0;
      tick();
      clear = 1'b0;
      model_new(0);
   endtask

   task automatic run(input int sz, input int full_pct, input int send_pct, input bit seq);
      int budget;
      model_new(sz);
      size_i   = 12'(sz);
      start    = 1'b1;
      OUT_send = 1'b0;
      fsl_full = 1'b0;
      tick();
      start  = 1'b0;
      budget = 0;
      while (busy && budget < 400) begin
         fsl_full = ($urandom_range(99) < full_pct);
         OUT_send = ($urandom_range(99) < send_pct);
         OUT_data = seq ? 32'(acc_seen + 1) : $urandom;
         tick();
         budget++;
      end
      OUT_send = 1'b0;
      fsl_full = 1'b0;
      if (busy) begin
         check("run_timeout", 0, 1);
         recover();
      end
   endtask

   task automatic drain_until_idle(input string name);
      int budget;
      budget = 0;
      while (busy && budget < 100) begin
         OUT_data = 32'(acc_seen + 1);
         tick();
         budget++;
      end
      if (busy) begin
         check(name, 0, 1);
         recover();
      end
   endtask

   initial begin
      vecs[0] = '{8,  0,  100, 1, 8,  1, 1};
      vecs[1] = '{6,  40, 80,  0, 6,  1, 0};
      vecs[2] = '{0,  0,  100, 0, 0,  0, 0};
      vecs[3] = '{1,  30, 100, 0, 1,  1, 0};
      vecs[4] = '{5,  0,  50,  0, 5,  1, 0};
      vecs[5] = '{12, 60, 100, 0, 12, 1, 0};
      vecs[6] = '{3,  20, 30,  1, 3,  1, 0};

      rst = 1'b1; start = 1'b0; clear = 1'b0; size_i = 12'd0;
      OUT_data = 32'd0; OUT_send = 1'b0; fsl_full = 1'b0;
      model_new(0);
      #2;
      check("rst_in_rdy", IN_rdy, 0);
      check("rst_write", FSL_M_WRITE, 0);
      check("rst_control", FSL_M_CONTROL, 0);
      check("rst_done", done, 0);
      check("rst_data", FSL_M_DATA, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick();

      // table-driven runs
      for (int v = 0; v < 7; v++) begin
         run(vecs[v].sz, vecs[v].full_pct, vecs[v].send_pct, vecs[v].seq);
         check("vec_writes", wr_seen, vecs[v].exp_wr);
         check("vec_ctrl", ctrl_seen, vecs[v].exp_ctrl);
         check("vec_drained", exp_q.size(), 0);
         if (vecs[v].tput) check("vec_throughput", last_wr - first_wr, vecs[v].sz - 1);
         tick();
      end

      // random runs
      for (int r = 0; r < 10; r++) begin
         int sz;
         sz = $urandom_range(0, 20);
         run(sz, $urandom_range(0, 70), $urandom_range(30, 100), 1'b0);
         check("rnd_writes", wr_seen, sz);
         check("rnd_ctrl", ctrl_seen, (sz != 0));
         check("rnd_drained", exp_q.size(), 0);
      end

      // backpressure: FSL full for 10 cycles, FIFO fills after 4 accepts
      model_new(6);
      size_i = 12'd6; fsl_full = 1'b1; start = 1'b1;
      tick();
      start = 1'b0; OUT_send = 1'b1;
      for (int k = 0; k < 10; k++) begin
         OUT_data = 32'(acc_seen + 1);
         tick();
      end
      check("bp_accepts", acc_seen, 4);
      check("bp_in_rdy", s_in_rdy, 0);
      check("bp_no_writes", wr_seen, 0);
      fsl_full = 1'b0;
      drain_until_idle("bp_timeout");
      OUT_send = 1'b0;
      check("bp_writes", wr_seen, 6);
      check("bp_drained", exp_q.size(), 0);

      // clear after 5 accepts, then a fresh run of 3
      model_new(10);
      size_i = 12'd10; start = 1'b1;
      tick();
      start = 1'b0; OUT_send = 1'b1;
      for (int k = 0; k < 20 && acc_seen < 5; k++) begin
         OUT_data = 32'(acc_seen + 1);
         tick();
      end
      check("clr_accepts", acc_seen, 5);
      OUT_send = 1'b0; clear = 1'b1;
      tick();
      clear = 1'b0;
      model_new(0);
      OUT_send = 1'b1;
      tick();
      check("clr_in_rdy", s_in_rdy, 0);
      check("clr_write", s_wr, 0);
      repeat (4) tick();
      OUT_send = 1'b0;
      run(3, 0, 100, 1'b1);
      check("clr_next_writes", wr_seen, 3);

      // async reset with 3 words buffered in DRAIN
      model_new(3);
      size_i = 12'd3; fsl_full = 1'b1; start = 1'b1;
      tick();
      start = 1'b0; OUT_send = 1'b1;
      repeat (3) begin
         OUT_data = 32'(acc_seen + 1);
         tick();
      end
      check("ar_accepts", acc_seen, 3);
      OUT_send = 1'b0; fsl_full = 1'b0;
      #1;
      check("ar_pre_write", FSL_M_WRITE, 1);
      rst = 1'b1;
      #1;
      check("ar_in_rdy", IN_rdy, 0);
      check("ar_write", FSL_M_WRITE, 0);
      check("ar_control", FSL_M_CONTROL, 0);
      check("ar_done", done, 0);
      check("ar_data", FSL_M_DATA, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_new(0);
      OUT_send = 1'b1;
      repeat (5) tick();
      OUT_send = 1'b0;
      check("ar_no_writes", wr_seen, 0);
      run(2, 0, 100, 1'b0);
      check("ar_next_writes", wr_seen, 2);

      // quota guard with an ignored start during RUN
      model_new(4);
      size_i = 12'd4; fsl_full = 1'b1; start = 1'b1;
      tick();
      start = 1'b0; OUT_send = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         OUT_data = 32'(acc_seen + 1);
         if (k == 3) begin
            start = 1'b1; size_i = 12'd2;
         end
         tick();
         start = 1'b0;
         if (k >= 5) check("qg_in_rdy_low", s_in_rdy, 0);
      end
      check("qg_accepts", acc_seen, 4);
      fsl_full = 1'b0;
      drain_until_idle("qg_timeout");
      OUT_send = 1'b0;
      check("qg_writes", wr_seen, 4);
      check("qg_ctrl", ctrl_seen, 1);
      repeat (3) tick();

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule

// File: doc/back_end.md
# back_end

Output stage of the stream coprocessor: collects result tokens from the datapath and writes them to the FSL master port. It accepts exactly `size` words per run through a small elastic FIFO and applies backpressure to the datapath when the FIFO is full or the quota is reached. It drains the FIFO into FSL, honouring `FSL_M_FULL`, flags the last word on `FSL_M_CONTROL`, and pulses `done` once the final word is written. It sits directly downstream of the datapath, mirroring the input stage.

## Interface
- `SIZECOUNT`, 12: width of the run length / word counters.
- `DATAWIDTH`, 32: token and FSL data width.
- `FIFOLOG2`, 2: log2 of FIFO depth (depth 4).
- `clk` in 1: system clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: begin a run; sampled only in IDLE.
- `clear` in 1: synchronous flush of counters, FIFO and FSM.
- `size` in SIZECOUNT: words per run; sampled on accepted `start`.
- `OUT_data` in DATAWIDTH: datapath result token.
- `OUT_send` in 1: datapath token valid.
- `IN_rdy` out 1: back_end ready to accept a token.
- `FSL_M_DATA` out DATAWIDTH: data to FSL master.
- `FSL_M_WRITE` out 1: FSL write strobe.
- `FSL_M_CONTROL` out 1: high with the last word of a run.
- `FSL_M_FULL` in 1: FSL master FIFO full.
- `done` out 1: one-cycle pulse, run complete.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: `start`=1 latches `size`, zeroes `acc_cnt` and `wr_cnt`, and goes to RUN. If `size`=0, it goes straight to DONE.
- RUN: `IN_rdy` = !fifo_full && (`acc_cnt` < size_q).
  - Accept = `OUT_send` && `IN_rdy`. An accept pushes `OUT_data` and increments `acc_cnt`.
  - When `acc_cnt` reaches size_q, the FSM goes to DRAIN.
- DRAIN: `IN_rdy`=0. When `wr_cnt` = size_q, the FSM goes to DONE.
- RUN and DRAIN, write path: `FSL_M_WRITE` = !fifo_empty && !`FSL_M_FULL`.
  - `FSL_M_DATA` = FIFO head (show-ahead). Each write pops the FIFO and increments `wr_cnt`.
  - `FSL_M_CONTROL` = `FSL_M_WRITE` && (`wr_cnt` = size_q−1).
- DONE: `done`=1 for exactly one cycle, then the FSM returns to IDLE.
- In IDLE and DONE, `IN_rdy`=0 and `FSL_M_WRITE`=0.
- `start` is ignored outside IDLE. `OUT_send` while `IN_rdy`=0 is not accepted; the datapath holds its token.
- Simultaneous push and pop is allowed in any occupancy, including full. A pop on full frees a slot, but `IN_rdy` reflects the registered full flag only, so no combinational full→rdy path through `FSL_M_FULL`.
- `clear` has priority over `start` and all other activity:
  - FIFO emptied, counters zeroed, state IDLE next cycle.
  - No `done` is generated for the flushed run.
- `rst` (any time, including mid-run) forces IDLE asynchronously and empties the FIFO. Buffered words are lost.
- Counters are SIZECOUNT bits. size_q ≤ 2^SIZECOUNT−1, so no counter wraps within a run.

## Timing
- Reset values:
  - `IN_rdy`=0, `FSL_M_WRITE`=0, `FSL_M_CONTROL`=0, `done`=0.
  - `FSL_M_DATA`=0.
  - State IDLE, counters 0, FIFO empty.
- `start` at cycle t → RUN at t+1. `IN_rdy` can be high at t+1.
- Token accepted at cycle t → earliest `FSL_M_WRITE` at t+1. FIFO write is registered; the head is visible the next cycle.
- Sustained throughput is 1 word/cycle when `OUT_send`=1 and `FSL_M_FULL`=0.
- Last FSL write at cycle t → state DONE at t+1, `done`=1 at t+1, IDLE at t+2. The earliest next `start` is accepted at t+2.
- `size`=0: `start` at t → `done` at t+1, no FSL writes.
- `IN_rdy`, `FSL_M_WRITE` and `FSL_M_CONTROL` are combinational from registered state plus `FSL_M_FULL`. No path from `OUT_send` to `IN_rdy`.

## Structure
- Shared package `stream_pkg`: state enum (IDLE/RUN/DRAIN/DONE) and default width constants (SIZECOUNT, DATAWIDTH). These are shared with the input stage.
- Sub-module `out_fifo`: synchronous show-ahead FIFO, depth 2^FIFOLOG2. It provides registered full/empty flags and push/pop/flush ports.
- Top level: FSM, `acc_cnt`, `wr_cnt`, handshake glue.

## Test plan
- **Basic run.** `size`=8, `OUT_send` constant, `FSL_M_FULL`=0, data 1..8.
  - Exactly 8 `FSL_M_WRITE` with data 1..8 in order.
  - `FSL_M_CONTROL` only on word 8.
  - `done` pulse 1 cycle after the last write.
- **Backpressure.** `size`=6, `FSL_M_FULL` held high for 10 cycles.
  - `IN_rdy` drops after 4 accepts (FIFO full).
  - No writes while full. All 6 words are delivered in order after release.
- **Zero size.** `size`=0, `start`.
  - `done` at the next cycle.
  - `IN_rdy`=0 and `FSL_M_WRITE`=0 throughout.
- **Clear mid-run.** `size`=10, `clear` after 5 accepts.
  - IDLE next cycle, FIFO empty, no `done`.
  - A following `start` with `size`=3 delivers exactly 3 words.
- **Async reset mid-drain.** Assert `rst` while 3 words are buffered.
  - All outputs 0 immediately. No writes until a new `start`.
- **Quota guard.** `size`=4, `OUT_send` held high beyond 4 tokens.
  - Only 4 accepted. `IN_rdy`=0 from the cycle after the 4th accept.
  - `start` pulsed during RUN is ignored.
